// File: rtl/text_console_writer.sv
// Text-mode frame buffer write side: turns a CPU byte stream into character writes
// at the cursor cell, with wrap, newline, backspace, row clear and full-screen clear.
module text_console_writer #(
   parameter int unsigned COLS      = 80,
   parameter int unsigned ROWS      = 60,
   parameter logic [14:0] ADDR_TEXT = 15'd0,
   parameter logic [7:0]  FILL_CHAR = 8'h20,
   parameter logic [7:0]  ATTR      = 8'h00
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        char_valid,
   input  logic [7:0]  char_data,
   output logic        char_ready,
   output logic        wr_en,
   output logic [14:0] wr_addr,
   output logic [15:0] wr_data,
   input  logic        wr_grant,
   output logic [5:0]  cursor_row,
   output logic [6:0]  cursor_col,
   output logic        busy
);

   typedef enum logic [1:0] {StClearAll, StIdle, StWrite, StClearRow} state_t;

   localparam logic [5:0] LastRow = 6'(ROWS - 1);
   localparam logic [6:0] LastCol = 7'(COLS - 1);

   state_t      state_q, state_d;
   logic [5:0]  row_q, row_d, clr_row_q, clr_row_d;
   logic [6:0]  col_q, col_d, clr_col_q, clr_col_d;
   logic [7:0]  char_q, char_d;
   logic        bs_q, bs_d;
   logic        wr_en_q, wr_en_d;
   logic        ready_q, ready_d;
   logic        busy_q, busy_d;
   logic [14:0] addr_q, addr_d;
   logic [15:0] data_q, data_d;
   logic        done;
   logic [5:0]  row_inc;

   assign done    = wr_en_q && wr_grant;
   assign row_inc = (row_q == LastRow) ? 6'd0 : row_q + 6'd1;

   always_comb begin
      state_d   = state_q;
      row_d     = row_q;
      col_d     = col_q;
      clr_row_d = clr_row_q;
      clr_col_d = clr_col_q;
      char_d    = char_q;
      bs_d      = bs_q;
      unique case (state_q)
         StClearAll: begin
            if (done) begin
               if (clr_col_q == LastCol) begin
                  clr_col_d = 7'd0;
                  if (clr_row_q == LastRow) begin
                     clr_row_d = 6'd0;
                     row_d     = 6'd0;
                     col_d     = 7'd0;
                     state_d   = StIdle;
                  end else begin
                     clr_row_d = clr_row_q + 6'd1;
                  end
               end else begin
                  clr_col_d = clr_col_q + 7'd1;
               end
            end
         end
         StIdle: begin
            if (char_valid && ready_q) begin
               case (char_data)
                  8'h0A: begin
                     col_d     = 7'd0;
                     row_d     = row_inc;
                     clr_col_d = 7'd0;
                     state_d   = StClearRow;
                  end
                  8'h0D: col_d = 7'd0;
                  8'h08: begin
                     if (col_q != 7'd0) begin
                        col_d   = col_q - 7'd1;
                        char_d  = FILL_CHAR;
                        bs_d    = 1'b1;
                        state_d = StWrite;
                     end
                  end
                  8'h0C: begin
                     clr_row_d = 6'd0;
                     clr_col_d = 7'd0;
                     state_d   = StClearAll;
                  end
                  default: begin
                     char_d  = char_data;
                     bs_d    = 1'b0;
                     state_d = StWrite;
                  end
               endcase
            end
         end
         StWrite: begin
            if (done) begin
               // Backspace writes the fill in place without moving the cursor.
               if (bs_q) begin
                  state_d = StIdle;
               end else if (col_q == LastCol) begin
                  col_d     = 7'd0;
                  row_d     = row_inc;
                  clr_col_d = 7'd0;
                  state_d   = StClearRow;
               end else begin
                  col_d   = col_q + 7'd1;
                  state_d = StIdle;
               end
            end
         end
         StClearRow: begin
            if (done) begin
               if (clr_col_q == LastCol) begin
                  clr_col_d = 7'd0;
                  state_d   = StIdle;
               end else begin
                  clr_col_d = clr_col_q + 7'd1;
               end
            end
         end
         default: state_d = StClearAll;
      endcase

      // Outputs are computed from the next state so they can be registered.
      addr_d = addr_q;
      data_d = data_q;
      unique case (state_d)
         StClearAll: begin
            addr_d = ADDR_TEXT + {2'b00, clr_row_d, clr_col_d};
            data_d = {ATTR, FILL_CHAR};
         end
         StClearRow: begin
            addr_d = ADDR_TEXT + {2'b00, row_d, clr_col_d};
            data_d = {ATTR, FILL_CHAR};
         end
         StWrite: begin
            addr_d = ADDR_TEXT + {2'b00, row_d, col_d};
            data_d = {ATTR, char_d};
         end
         default: ;
      endcase
      wr_en_d = (state_d != StIdle);
      ready_d = (state_d == StIdle);
      busy_d  = (state_d != StIdle);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StClearAll;
         row_q     <= 6'd0;
         col_q     <= 7'd0;
         clr_row_q <= 6'd0;
         clr_col_q <= 7'd0;
         char_q    <= FILL_CHAR;
         bs_q      <= 1'b0;
         wr_en_q   <= 1'b0;
         ready_q   <= 1'b0;
         busy_q    <= 1'b1;
         addr_q    <= ADDR_TEXT;
         data_q    <= {ATTR, FILL_CHAR};
      end else begin
         state_q   <= state_d;
         row_q     <= row_d;
         col_q     <= col_d;
         clr_row_q <= clr_row_d;
         clr_col_q <= clr_col_d;
         char_q    <= char_d;
         bs_q      <= bs_d;
         wr_en_q   <= wr_en_d;
         ready_q   <= ready_d;
         busy_q    <= busy_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
      end
   end

   assign char_ready = ready_q;
   assign wr_en      = wr_en_q;
   assign wr_addr    = addr_q;
   assign wr_data    = data_q;
   assign cursor_row = row_q;
   assign cursor_col = col_q;
   assign busy       = busy_q;

endmodule
